// File: rtl/commit_flush_ctrl_pkg.sv
// commit_flush_ctrl_pkg: shared encodings and widths for the ROB commit/flush controller
package commit_flush_ctrl_pkg;
  localparam int REG_WIDTH = 32;
  localparam int LS_BUFFER_ID_WIDTH = 4;
  typedef logic [REG_WIDTH-1:0] reg_t;
  typedef logic [LS_BUFFER_ID_WIDTH-1:0] ls_buffer_id_t;
  typedef enum logic [1:0] {HT_OTHER, HT_STORE, HT_BRANCH, HT_JALR} head_type_t;
  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;
endpackage

// File: rtl/commit_flush_ctrl.sv
// commit_flush_ctrl: retires the ROB head and drives the mispredict flush triple
module commit_flush_ctrl
  import commit_flush_ctrl_pkg::*;
#(
  parameter int LS_ID_WIDTH = LS_BUFFER_ID_WIDTH,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   head_valid_in,
  input  logic                   head_ready_in,
  input  logic [1:0]             head_type_in,
  input  logic [31:0]            head_pc_in,
  input  logic                   head_pred_taken_in,
  input  logic                   head_real_taken_in,
  input  logic [31:0]            head_target_in,
  input  logic [LS_ID_WIDTH-1:0] head_ls_id_in,
  output logic                   commit_out,
  output logic                   reset_out,
  output logic [31:0]            pc_out,
  output logic [LS_ID_WIDTH-1:0] dest_out,
  output logic [31:0]            commit_cnt_out,
  output logic [31:0]            mispredict_cnt_out
);
  state_t state, state_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic mispredict, flush_go;
  logic [31:0] redirect;
  always_comb begin
    mispredict = (head_type_in == HT_JALR) ||
                 (head_type_in == HT_BRANCH && head_pred_taken_in != head_real_taken_in);
    redirect = (head_type_in == HT_BRANCH && !head_real_taken_in) ? head_pc_in + 32'd4 : head_target_in;
    flush_go = commit_out && mispredict;
  end
  always_comb begin
    state_nxt = (state == ST_IDLE) ? (flush_go ? ST_FLUSH : ST_IDLE)
                                   : (fcnt == 4'd0 ? ST_IDLE : ST_FLUSH);
    fcnt_nxt = flush_go ? 4'(FLUSH_CYCLES - 1)
             : (state == ST_FLUSH && fcnt != 4'd0) ? fcnt - 4'd1 : fcnt;
  end
  always_comb commit_out = rdy_in && !rst_in && state == ST_IDLE && head_valid_in && head_ready_in;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= ST_IDLE;
      fcnt               <= '0;
      reset_out          <= 1'b0;
      pc_out             <= '0;
      dest_out           <= '0;
      commit_cnt_out     <= '0;
      mispredict_cnt_out <= '0;
    end else if (rdy_in) begin
      state     <= state_nxt;
      fcnt      <= fcnt_nxt;
      reset_out <= state_nxt == ST_FLUSH;
      if (commit_out) commit_cnt_out <= commit_cnt_out + 32'd1;
      if (commit_out && head_type_in == HT_STORE) dest_out <= head_ls_id_in + LS_ID_WIDTH'(1);
      if (flush_go) begin
        pc_out             <= redirect;
        mispredict_cnt_out <= mispredict_cnt_out + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_commit_flush_ctrl.sv
// tb_commit_flush_ctrl: directed checks of commit, store wrap, flush timing, stall and reset
module tb_commit_flush_ctrl;
  logic clk = 0, rst = 1, rdy = 1, hv = 0, hr = 0, pt = 0, rt = 0;
  logic [1:0] ht = 0;
  logic [31:0] hpc = 0, htg = 0;
  logic [3:0] hid = 0;
  logic c1, r1, c3, r3;
  logic [31:0] p1, cc1, mc1, p3, cc3, mc3;
  logic [3:0] d1, d3;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  commit_flush_ctrl #(.LS_ID_WIDTH(4), .FLUSH_CYCLES(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .head_valid_in(hv), .head_ready_in(hr),
    .head_type_in(ht), .head_pc_in(hpc), .head_pred_taken_in(pt), .head_real_taken_in(rt),
    .head_target_in(htg), .head_ls_id_in(hid), .commit_out(c1), .reset_out(r1), .pc_out(p1),
    .dest_out(d1), .commit_cnt_out(cc1), .mispredict_cnt_out(mc1));
  commit_flush_ctrl #(.LS_ID_WIDTH(4), .FLUSH_CYCLES(3)) dut3 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .head_valid_in(hv), .head_ready_in(hr),
    .head_type_in(ht), .head_pc_in(hpc), .head_pred_taken_in(pt), .head_real_taken_in(rt),
    .head_target_in(htg), .head_ls_id_in(hid), .commit_out(c3), .reset_out(r3), .pc_out(p3),
    .dest_out(d3), .commit_cnt_out(cc3), .mispredict_cnt_out(mc3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic head(input logic [1:0] t, input logic [31:0] pc, input logic p, input logic r,
                      input logic [31:0] tg, input logic [3:0] id);
    hv = 1; hr = 1; ht = t; hpc = pc; pt = p; rt = r; htg = tg; hid = id;
    #1;
  endtask
  task automatic do_reset();
    rst = 1; hv = 0;
    tick();
    rst = 0;
  endtask
  initial begin
    // reset with a live head must not commit
    rst = 1; head(2'd0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_commit", 32'(c1), 0);
    chk("rst_reset_out", 32'(r1), 0);
    chk("rst_dest", 32'(d1), 0);
    chk("rst_ccnt", cc1, 0);
    chk("rst_mcnt", mc1, 0);
    chk("rst_pc", p1, 0);
    rst = 0; #1;
    chk("idle_commit", 32'(c1), 1);
    // store ls_id wrap
    do_reset();
    head(2'd1, 0, 0, 0, 0, 4'd3);
    chk("st1_commit", 32'(c1), 1);
    tick();
    chk("st1_dest", 32'(d1), 4);
    chk("st1_ccnt", cc1, 1);
    hid = 4'd15;
    tick();
    chk("st2_dest", 32'(d1), 0);
    chk("st2_ccnt", cc1, 2);
    chk("st2_reset_out", 32'(r1), 0);
    // branch mispredict, not taken: redirect pc+4
    head(2'd2, 32'h100, 1, 0, 32'h200, 0);
    chk("br_commit", 32'(c1), 1);
    tick();
    head(2'd0, 0, 0, 0, 0, 0);
    chk("br_reset_out", 32'(r1), 1);
    chk("br_pc", p1, 32'h104);
    chk("br_flush_commit", 32'(c1), 0);
    chk("br_mcnt", mc1, 1);
    chk("br_ccnt", cc1, 3);
    chk("br_dest_kept", 32'(d1), 0);
    tick();
    chk("br_reset_end", 32'(r1), 0);
    chk("br_commit_after", 32'(c1), 1);
    // correct branch then JALR with 3 flush cycles
    do_reset();
    head(2'd2, 32'h40, 1, 1, 32'h300, 0);
    chk("ok_commit", 32'(c3), 1);
    tick();
    chk("ok_reset_out", 32'(r3), 0);
    chk("ok_mcnt", mc3, 0);
    chk("ok_ccnt", cc3, 1);
    head(2'd3, 32'h50, 0, 0, 32'h80, 0);
    tick();
    head(2'd0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("jalr_reset_c%0d", i), 32'(r3), 1);
      chk($sformatf("jalr_commit_c%0d", i), 32'(c3), 0);
      tick();
    end
    chk("jalr_pc", p3, 32'h80);
    chk("jalr_reset_end", 32'(r3), 0);
    chk("jalr_commit_c4", 32'(c3), 1);
    chk("jalr_mcnt", mc3, 1);
    // rdy stall inside a 3-cycle flush
    do_reset();
    head(2'd3, 0, 0, 0, 32'h90, 0);
    tick();
    head(2'd0, 0, 0, 0, 0, 0);
    chk("stall_w1", 32'(r3), 1);
    tick();
    chk("stall_w2", 32'(r3), 1);
    rdy = 0; #1;
    for (int i = 3; i <= 4; i++) begin
      tick();
      chk($sformatf("stall_w%0d", i), 32'(r3), 1);
      chk($sformatf("stall_commit_w%0d", i), 32'(c3), 0);
      chk($sformatf("stall_ccnt_w%0d", i), cc3, 1);
      chk($sformatf("stall_mcnt_w%0d", i), mc3, 1);
    end
    rdy = 1;
    tick();
    chk("stall_w5", 32'(r3), 1);
    tick();
    chk("stall_w6_low", 32'(r3), 0);
    chk("stall_commit_after", 32'(c3), 1);
    // reset during the second flush cycle
    do_reset();
    head(2'd3, 0, 0, 0, 32'hA0, 0);
    tick();
    head(2'd0, 0, 0, 0, 0, 0);
    tick();
    chk("midrst_flushing", 32'(r3), 1);
    rst = 1;
    tick();
    rst = 0; #1;
    chk("midrst_reset_out", 32'(r3), 0);
    chk("midrst_commit", 32'(c3), 1);
    chk("midrst_mcnt", mc3, 0);
    chk("midrst_pc", p3, 0);
    hv = 0; #1;
    chk("midrst_noval", 32'(c3), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/commit_flush_ctrl.md
Name: commit_flush_ctrl

Overview:
- Sits at the head of the reorder buffer and owns the retire decision for the head entry.
- Detects control-flow mispredicts at retire and generates the flush triple on the rob bus: reset pulse, redirect PC, and load/store-buffer restore point.
- Tracks the load/store-buffer slot following the last committed store, so uncommitted memory ops are discarded on flush.
- Keeps commit and mispredict counters for performance debug.

Parameters:
- LS_ID_WIDTH, 4, width of a load/store-buffer entry ID (matches LS_BUFFER_ID_TYPE).
- FLUSH_CYCLES, 1, number of cycles reset_out stays high per flush (legal range 1..15).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  global ready; when low all state is frozen
- head_valid_in  input  1  ROB head entry exists
- head_ready_in  input  1  head entry result is written back
- head_type_in  input  2  0=OTHER, 1=STORE, 2=BRANCH, 3=JALR
- head_pc_in  input  32  PC of head instruction
- head_pred_taken_in  input  1  predictor direction used at fetch
- head_real_taken_in  input  1  resolved direction (BRANCH only)
- head_target_in  input  32  resolved target address
- head_ls_id_in  input  LS_ID_WIDTH  LS-buffer ID (STORE only)
- commit_out  output  1  pop head this cycle
- reset_out  output  1  flush pulse driven onto the rob bus
- pc_out  output  32  redirect PC for the instruction fetcher
- dest_out  output  LS_ID_WIDTH  LS-buffer restore tail
- commit_cnt_out  output  32  retired-instruction count
- mispredict_cnt_out  output  32  flush count

Behaviour:
- Reset (rst_in=1 at a clock edge) clears all registers:
  - state=IDLE
  - reset_out=0, pc_out=0, dest_out=0
  - both counters=0
  - flush counter=0
  - rst_in has priority over rdy_in and over any state, including mid-flush.
- Freeze: if rdy_in=0, no register changes and commit_out=0. reset_out holds its value.
- commit_out (combinational) = rdy_in & state==IDLE & head_valid_in & head_ready_in.
- On a commit, the following register updates occur at the next edge:
  - commit_cnt_out += 1, wrapping at 2^32.
  - STORE: dest_out <= head_ls_id_in + 1, mod 2^LS_ID_WIDTH, so an ID of all-ones wraps to 0.
  - BRANCH: mispredict iff head_pred_taken_in != head_real_taken_in. Redirect = head_target_in if real_taken, else head_pc_in + 4 (32-bit wrap).
  - JALR: always a mispredict. Redirect = head_target_in.
  - OTHER: no flush.
- On a mispredict commit, the following register updates occur at the next edge:
  - state <= FLUSH
  - reset_out <= 1
  - pc_out <= redirect
  - flush counter <= FLUSH_CYCLES-1
  - mispredict_cnt_out += 1
- FLUSH state:
  - commit_out=0 regardless of head inputs.
  - Each ready cycle: if the flush counter is 0, then state <= IDLE and reset_out <= 0. Otherwise decrement the counter.
  - reset_out is therefore high for exactly FLUSH_CYCLES ready cycles, starting the cycle after the commit.
- pc_out and dest_out hold their values outside flush. They are only meaningful while reset_out=1.
- dest_out is unchanged by the flush itself.
- Latency:
  - commit is 0-cycle (combinational from the head inputs).
  - flush start is 1 cycle after the mispredicting commit.
  - the first commit after a flush happens no earlier than FLUSH_CYCLES+1 cycles after the mispredict commit.
- Back-to-back non-flush commits run one per cycle.
- Head inputs are ignored whenever head_valid_in=0.

Decomposition:
- Shared config package/header holds:
  - the head-type encodings (OTHER/STORE/BRANCH/JALR)
  - the state encodings (IDLE/FLUSH)
  - REG_TYPE / LS_BUFFER_ID_TYPE width macros
- No sub-module. The redirect/mispredict logic is a small combinational block inside this module.

Test Plan:
- Reset: drive rst_in=1 for 2 cycles with head_valid_in=1 and head_ready_in=1 -> commit_out=0, reset_out=0, dest_out=0, both counters 0.
- Store wrap: commit STOREs with ls_id 3, then 15 (LS_ID_WIDTH=4) -> dest_out=4, then 0. commit_cnt_out=2. No reset_out.
- Branch mispredict: BRANCH with pc=0x100, pred=1, real=0, target=0x200 -> next cycle reset_out=1 and pc_out=0x104. reset_out is high for exactly 1 cycle, commit_out=0 during it, mispredict_cnt_out=1.
- Correct branch then JALR with FLUSH_CYCLES=3: BRANCH with pred=real=1 commits with no flush. JALR with target=0x80 -> reset_out high 3 cycles, pc_out=0x80, next commit no earlier than cycle 4.
- rdy_in stall: drop rdy_in for 2 cycles in the middle of a 3-cycle flush -> reset_out stays high for 5 wall-clock cycles and the counters are unchanged while stalled.
- Reset mid-flush: assert rst_in in the 2nd cycle of FLUSH -> next cycle state=IDLE, reset_out=0, commit_out follows the head inputs.
